// File: rtl/rf_pkg.sv
// Shared types and constants for the multi-port register file and its clear engine.
// Zero latency: constants and a constant-evaluable log2 helper only; no flow control.
package rf_pkg;

    localparam int RF_WIDTH_DEF = 32;
    localparam int RF_DEPTH_DEF = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

    // Smallest r such that 2^r >= n.
    function automatic int rf_clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rf_clear_ctrl.sv
// Background clear engine: zeroes one register-file entry per cycle while busy.
// Busy one cycle after the request and for exactly DEPTH cycles; requests while busy are ignored.
module rf_clear_ctrl
    import rf_pkg::*;
#(
    parameter int DEPTH     = RF_DEPTH_DEF,
    parameter int ADDR_BITS = 5
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clr_req_i,
    output logic                 busy_o,
    output logic [ADDR_BITS-1:0] clr_addr_o,
    output logic                 clr_stb_o
);

    localparam logic [ADDR_BITS-1:0] LAST = ADDR_BITS'(DEPTH - 1);

    clr_state_e           state_q, state_d;
    logic [ADDR_BITS-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        clr_stb_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (clr_req_i) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                clr_stb_o = 1'b1;
                // The counter parks at zero rather than wrapping past the last entry.
                if (cnt_q == LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_BITS'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign busy_o     = (state_q == CLEAR);
    assign clr_addr_o = cnt_q;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with write priority, conflict flag, same-cycle bypass and background clear.
// Reads are combinational (zero latency); writes land on the next edge and are dropped while clearing.
module reg_file_mp
    import rf_pkg::*;
#(
    parameter int WIDTH     = RF_WIDTH_DEF,
    parameter int DEPTH     = RF_DEPTH_DEF,
    parameter int ADDR_BITS = 5,
    parameter int NUM_RD    = 2,
    parameter int NUM_WR    = 2,
    parameter int ZERO_REG  = 1,
    parameter int BYPASS    = 1
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [NUM_RD*ADDR_BITS-1:0] RA,
    output logic [NUM_RD*WIDTH-1:0]     RD,
    input  logic [NUM_WR*ADDR_BITS-1:0] WA,
    input  logic [NUM_WR*WIDTH-1:0]     WD,
    input  logic [NUM_WR-1:0]           WE,
    input  logic                        CLR_REQ,
    output logic                        CLR_BUSY,
    output logic                        WR_CONFLICT
);

    localparam int                   IDX_BITS = (DEPTH > 1) ? rf_clog2(DEPTH) : 1;
    localparam logic [ADDR_BITS:0]   DEPTH_X  = (ADDR_BITS + 1)'(DEPTH);

    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic [ADDR_BITS-1:0] ra_a  [NUM_RD];
    logic [WIDTH-1:0]     rd_a  [NUM_RD];
    logic [ADDR_BITS-1:0] wa_a  [NUM_WR];
    logic [WIDTH-1:0]     wd_a  [NUM_WR];
    logic [NUM_WR-1:0]    we_eff;
    logic                 conflict_q, conflict_d;

    logic                 clr_busy;
    logic                 clr_stb;
    logic [ADDR_BITS-1:0] clr_addr;

    rf_clear_ctrl #(
        .DEPTH     (DEPTH),
        .ADDR_BITS (ADDR_BITS)
    ) u_clear (
        .clk_i      (CLK),
        .rst_i      (RST),
        .clr_req_i  (CLR_REQ),
        .busy_o     (clr_busy),
        .clr_addr_o (clr_addr),
        .clr_stb_o  (clr_stb)
    );

    // Write qualification: out-of-range, entry-0 (when hardwired) and clear-time writes are dropped.
    always_comb begin
        we_eff = '0;
        for (int k = 0; k < NUM_WR; k++) begin
            wa_a[k]   = WA[k*ADDR_BITS +: ADDR_BITS];
            wd_a[k]   = WD[k*WIDTH +: WIDTH];
            we_eff[k] = WE[k] && !clr_busy
                        && ({1'b0, wa_a[k]} < DEPTH_X)
                        && !((ZERO_REG != 0) && (wa_a[k] == '0));
        end
    end

    always_comb begin
        conflict_d = 1'b0;
        for (int i = 0; i < NUM_WR; i++) begin
            for (int j = i + 1; j < NUM_WR; j++) begin
                if (we_eff[i] && we_eff[j] && (wa_a[i] == wa_a[j])) begin
                    conflict_d = 1'b1;
                end
            end
        end
    end

    // Later port indices overwrite earlier ones, both in the bypass mux and in the array.
    always_comb begin
        RD = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            ra_a[p] = RA[p*ADDR_BITS +: ADDR_BITS];
            rd_a[p] = '0;
            if (({1'b0, ra_a[p]} < DEPTH_X) && !((ZERO_REG != 0) && (ra_a[p] == '0))) begin
                rd_a[p] = mem_q[ra_a[p][IDX_BITS-1:0]];
                if (BYPASS != 0) begin
                    for (int k = 0; k < NUM_WR; k++) begin
                        if (we_eff[k] && (wa_a[k] == ra_a[p])) begin
                            rd_a[p] = wd_a[k];
                        end
                    end
                end
            end
            RD[p*WIDTH +: WIDTH] = rd_a[p];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            conflict_q <= 1'b0;
        end else begin
            conflict_q <= conflict_d;
            if (clr_stb) begin
                mem_q[clr_addr[IDX_BITS-1:0]] <= '0;
            end
            for (int k = 0; k < NUM_WR; k++) begin
                if (we_eff[k]) begin
                    mem_q[wa_a[k][IDX_BITS-1:0]] <= wd_a[k];
                end
            end
        end
    end

    assign CLR_BUSY    = clr_busy;
    assign WR_CONFLICT = conflict_q;

endmodule
